// File: rtl/bit_stuff.sv
// -----------------------------------------------------------------------------
// bit_stuff -- bit stuffer between the packet encoder and the NRZI encoder.
//
// Accepts one packet bit per handshake and forwards it on a registered output
// stream. After every six consecutive 1s on the output, a single 0 is inserted.
// The run is counted on the output stream, so an inserted 0 restarts it. When
// the sixth 1 is the last bit of the packet, the stuff 0 is still sent before
// the packet is closed.
//
// Ports
//   clk         : single clock, rising edge
//   rst_L       : synchronous active-low reset
//   in_bit      : packet bit (already in LSB-first order)
//   in_valid    : in_bit/in_start/in_last are valid this cycle
//   in_start    : first bit of a packet (qualified by in_valid)
//   in_last     : final bit of a packet (qualified by in_valid, may equal start)
//   in_ready    : combinational; a bit is taken when in_valid & in_ready
//   outb        : registered stuffed bit stream (to nrzi inb)
//   out_valid   : registered; outb carries a packet bit
//   data_start  : registered pulse on the first output bit
//   data_end    : registered pulse in the cycle after the final output bit
//   underrun    : registered pulse when the input ran dry mid-packet
//   stuff_cnt   : (only with BIT_STUFF_CNT_EN) stuff bits in current/last packet
//
// Build option
//   BIT_STUFF_CNT_EN : when defined, adds the stuff_cnt[7:0] output. It is
//                      cleared on the data_start edge, counts each inserted
//                      stuff bit, saturates at 255 and holds after data_end.
// -----------------------------------------------------------------------------
module bit_stuff (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_start,
    input  logic       in_last,
    output logic       in_ready,
    output logic       outb,
    output logic       out_valid,
    output logic       data_start,
    output logic       data_end,
    output logic       underrun
`ifdef BIT_STUFF_CNT_EN
    ,
    output logic [7:0] stuff_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STUFF = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t     state_reg, state_next;

    logic [2:0] ones_reg, ones_next;
    logic       last_pend_reg, last_pend_next;
    logic       outb_reg, outb_next;
    logic       out_valid_reg, out_valid_next;
    logic       data_start_reg, data_start_next;
    logic       data_end_reg, data_end_next;
    logic       underrun_reg, underrun_next;

    // An accepted 1 while five 1s are already on the wire makes the sixth.
    logic       stuff_due;
    assign stuff_due = in_bit && (ones_reg == 3'd5);

    assign in_ready   = (state_reg == S_IDLE) || (state_reg == S_RUN);
    assign outb       = outb_reg;
    assign out_valid  = out_valid_reg;
    assign data_start = data_start_reg;
    assign data_end   = data_end_reg;
    assign underrun   = underrun_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                // A one-bit packet (start and last together) can never need
                // a stuff, so it goes straight to END.
                if (in_valid && in_start) begin
                    state_next = in_last ? S_END : S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    if (stuff_due) begin
                        state_next = S_STUFF;
                    end else if (in_last) begin
                        state_next = S_END;
                    end else begin
                        state_next = S_RUN;
                    end
                end else begin
                    // Encoder stalled mid-packet: abort.
                    state_next = S_IDLE;
                end
            end
            S_STUFF: state_next = last_pend_reg ? S_END : S_RUN;
            S_END:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        outb_next       = outb_reg;
        out_valid_next  = out_valid_reg;
        data_start_next = 1'b0;
        data_end_next   = 1'b0;
        underrun_next   = 1'b0;
        ones_next       = ones_reg;
        last_pend_next  = last_pend_reg;
        case (state_reg)
            S_IDLE: begin
                outb_next      = 1'b0;
                out_valid_next = 1'b0;
                // Bits without in_start are swallowed here.
                if (in_valid && in_start) begin
                    outb_next       = in_bit;
                    out_valid_next  = 1'b1;
                    data_start_next = 1'b1;
                    ones_next       = {2'b00, in_bit};
                    last_pend_next  = 1'b0;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    outb_next      = in_bit;
                    out_valid_next = 1'b1;
                    ones_next      = in_bit ? (ones_reg + 3'd1) : 3'd0;
                    // Remember the packet ended so STUFF closes it afterwards.
                    last_pend_next = stuff_due && in_last;
                end else begin
                    outb_next      = 1'b0;
                    out_valid_next = 1'b0;
                    data_end_next  = 1'b1;
                    underrun_next  = 1'b1;
                    ones_next      = 3'd0;
                    last_pend_next = 1'b0;
                end
            end
            S_STUFF: begin
                outb_next      = 1'b0;
                out_valid_next = 1'b1;
                ones_next      = 3'd0;
            end
            S_END: begin
                // The final bit has been on outb for one cycle; close out.
                outb_next      = 1'b0;
                out_valid_next = 1'b0;
                data_end_next  = 1'b1;
                ones_next      = 3'd0;
                last_pend_next = 1'b0;
            end
            default: begin
                outb_next      = 1'b0;
                out_valid_next = 1'b0;
                ones_next      = 3'd0;
                last_pend_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            outb_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            data_start_reg <= 1'b0;
            data_end_reg   <= 1'b0;
            underrun_reg   <= 1'b0;
            ones_reg       <= 3'd0;
            last_pend_reg  <= 1'b0;
        end else begin
            outb_reg       <= outb_next;
            out_valid_reg  <= out_valid_next;
            data_start_reg <= data_start_next;
            data_end_reg   <= data_end_next;
            underrun_reg   <= underrun_next;
            ones_reg       <= ones_next;
            last_pend_reg  <= last_pend_next;
        end
    end

`ifdef BIT_STUFF_CNT_EN
    // ------------------------------------------------------------------
    // Per-packet stuff bit counter
    // ------------------------------------------------------------------
    logic [7:0] stuff_cnt_reg, stuff_cnt_next;

    always_comb begin
        stuff_cnt_next = stuff_cnt_reg;
        if (state_reg == S_IDLE && in_valid && in_start) begin
            stuff_cnt_next = 8'd0;
        end else if (state_reg == S_STUFF && stuff_cnt_reg != 8'hFF) begin
            stuff_cnt_next = stuff_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            stuff_cnt_reg <= 8'd0;
        end else begin
            stuff_cnt_reg <= stuff_cnt_next;
        end
    end

    assign stuff_cnt = stuff_cnt_reg;
`endif

endmodule

// File: tb/tb_bit_stuff.sv
// -----------------------------------------------------------------------------
// tb_bit_stuff -- self-checking bench for bit_stuff.
//
// A driver presents packets through the valid/ready handshake. For each packet
// a reference model computes the expected stuffed stream from the rule
// "insert a 0 after every six consecutive output 1s" and pushes it onto a
// scoreboard. A monitor samples the outputs 1 time unit after each rising
// edge, collects the output bits and compares them at every data_end.
// Directed packets come first, followed by randomized ones.
// -----------------------------------------------------------------------------
module tb_bit_stuff;

    logic clk;
    logic rst_L;
    logic in_bit, in_valid, in_start, in_last;
    logic in_ready, outb, out_valid, data_start, data_end, underrun;
`ifdef BIT_STUFF_CNT_EN
    logic [7:0] stuff_cnt;
`endif

    bit_stuff dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_start   (in_start),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .outb       (outb),
        .out_valid  (out_valid),
        .data_start (data_start),
        .data_end   (data_end),
        .underrun   (underrun)
`ifdef BIT_STUFF_CNT_EN
        ,
        .stuff_cnt  (stuff_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result of one packet.
    typedef struct {
        logic [63:0] bits;
        int          len;
        logic        urun;
        int          nstuff;
        int          stalls;
    } exp_t;

    exp_t sb[$];

    // Reference: walk the accepted input bits, emit each, and after six 1s in
    // a row on the output emit a 0 and restart the run. A stuff triggered by
    // any bit but the last one presented costs the driver one stalled cycle.
    function automatic exp_t model(input logic [63:0] bits, input int m, input logic urun);
        exp_t e;
        int   run;
        e.bits   = '0;
        e.len    = 0;
        e.urun   = urun;
        e.nstuff = 0;
        e.stalls = 0;
        run      = 0;
        for (int j = 0; j < m; j++) begin
            e.bits[e.len] = bits[j];
            e.len++;
            run = bits[j] ? run + 1 : 0;
            if (run == 6) begin
                e.bits[e.len] = 1'b0;
                e.len++;
                run = 0;
                e.nstuff++;
                if (j < m - 1) e.stalls++;
            end
        end
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [63:0] got_bits = '0;
    int          got_len  = 0;
    int          stray_ds = 0, stray_ur = 0, stray_end = 0, pulse_err = 0;
    logic        prev_ov = 1'b0, prev_ds = 1'b0, prev_de = 1'b0, prev_ur = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_L) begin
            chk("rst_outb",       64'(outb),       64'(0));
            chk("rst_out_valid",  64'(out_valid),  64'(0));
            chk("rst_data_start", 64'(data_start), 64'(0));
            chk("rst_data_end",   64'(data_end),   64'(0));
            chk("rst_underrun",   64'(underrun),   64'(0));
            chk("rst_in_ready",   64'(in_ready),   64'(1));
`ifdef BIT_STUFF_CNT_EN
            chk("rst_stuff_cnt",  64'(stuff_cnt),  64'(0));
`endif
            got_len  = 0;
            got_bits = '0;
            prev_ov  = 1'b0;
            prev_ds  = 1'b0;
            prev_de  = 1'b0;
            prev_ur  = 1'b0;
        end else begin
            if (out_valid) begin
                if (got_len == 0) begin
                    chk("ds_on_first_bit", 64'(data_start), 64'(1));
`ifdef BIT_STUFF_CNT_EN
                    chk("cnt_cleared_at_start", 64'(stuff_cnt), 64'(0));
`endif
                end else if (data_start) begin
                    stray_ds++;
                end
                if (got_len < 64) got_bits[got_len] = outb;
                got_len++;
            end else if (data_start) begin
                stray_ds++;
            end

            if (data_end) begin
                chk("end_after_bit", 64'(prev_ov), 64'(1));
                chk("end_ov_low", 64'(out_valid), 64'(0));
                if (sb.size() == 0) begin
                    stray_end++;
                end else begin
                    e = sb.pop_front();
                    chk("pkt_len",  64'(got_len),  64'(e.len));
                    chk("pkt_bits", got_bits,      e.bits);
                    chk("underrun", 64'(underrun), 64'(e.urun));
`ifdef BIT_STUFF_CNT_EN
                    chk("stuff_cnt", 64'(stuff_cnt), 64'(e.nstuff));
`endif
                    $display("pkt done: len=%0d bits=%0h urun=%0d stuffs=%0d", got_len, got_bits, underrun, e.nstuff);
                end
                got_len  = 0;
                got_bits = '0;
            end else if (underrun) begin
                stray_ur++;
            end

            if ((prev_ds && data_start) || (prev_de && data_end) || (prev_ur && underrun))
                pulse_err++;
            prev_ov = out_valid;
            prev_ds = data_start;
            prev_de = data_end;
            prev_ur = underrun;
        end
    end

    // ------------------------------------------------------------------
    // Driver (called at a falling edge, returns at a falling edge)
    // ------------------------------------------------------------------
    // cut > 0 and < n: present only the first cut bits, then drop in_valid.
    task automatic send_pkt(input logic [63:0] bits, input int n, input int cut);
        int   m, stalls, guard;
        logic rdy;
        exp_t e;
        m = (cut > 0 && cut < n) ? cut : n;
        e = model(bits, m, (m < n));
        sb.push_back(e);
        stalls = 0;
        for (int i = 0; i < m; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_start = (i == 0);
            in_last  = (i == n - 1);
            guard    = 0;
            rdy      = 1'b0;
            while (!rdy && guard < 20) begin
                #1;
                rdy = in_ready;
                @(negedge clk);
                if (!rdy) begin
                    guard++;
                    if (i > 0) stalls++;
                end
            end
            if (!rdy) chk("accept_timeout", 64'(rdy), 64'(1));
        end
        chk("in_ready_low_cycles", 64'(stalls), 64'(e.stalls));
        if (m < n) begin
            in_valid = 1'b0;
            in_start = 1'b0;
            in_last  = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        in_start = 1'b0;
        in_last  = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] rb;
        int          n, cut;

        rst_L    = 1'b0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        idle(1);

        send_pkt(64'b101, 3, 0);            idle(3);   // plain packet
        send_pkt(64'h7F, 8, 0);             idle(3);   // seven 1s then 0
        send_pkt(64'h3F, 6, 0);             idle(3);   // ends on sixth 1
        send_pkt(64'hB5, 8, 3);             idle(2);   // underrun after 3 bits
        send_pkt(64'h3FFF, 14, 0);          idle(3);   // two stuffs
        send_pkt(64'h1, 1, 0);                         // single-bit packet
        send_pkt(64'h3F, 6, 0);                        // back-to-back
        send_pkt(64'h2D, 6, 0);             idle(3);

        // Bit without in_start while idle is dropped.
        in_valid = 1'b1; in_bit = 1'b1; in_start = 1'b0; in_last = 1'b1;
        @(negedge clk);
        idle(2);

        // Reset during the 4th bit of a 10-bit packet.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bit   = (i != 1);
            in_start = (i == 0);
            in_last  = 1'b0;
            @(negedge clk);
        end
        in_bit = 1'b1;
        rst_L  = 1'b0;
        @(negedge clk);
        rst_L  = 1'b1;
        idle(3);
        send_pkt(64'h3FD, 10, 0);           idle(3);

        // Randomized packets, dense in 1s to exercise stuffing.
        for (int p = 0; p < 40; p++) begin
            n  = $urandom_range(1, 40);
            rb = '0;
            for (int j = 0; j < n; j++) rb[j] = ($urandom_range(0, 99) < 78);
            cut = 0;
            if (n > 1 && $urandom_range(0, 5) == 0) cut = $urandom_range(1, n - 1);
            send_pkt(rb, n, cut);
            if (cut == 0 && $urandom_range(0, 1) == 1) begin
                // next packet follows with no gap
            end else begin
                idle(3);
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b1; in_bit = 1'($urandom_range(0, 1));
                    in_start = 1'b0; in_last = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    idle(1);
                end
            end
        end
        idle(8);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("stray_data_start", 64'(stray_ds),  64'(0));
        chk("stray_underrun",   64'(stray_ur),  64'(0));
        chk("stray_data_end",   64'(stray_end), 64'(0));
        chk("double_pulse",     64'(pulse_err), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
